// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32IM decode / ID-EX control stage: opcodes,
// ALU operation codes, immediate and writeback selects, and the control bundle.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_XOR    = 5'b00001,
        ALU_AND    = 5'b00010,
        ALU_OR     = 5'b00011,
        ALU_MUL    = 5'b00100,
        ALU_MULH   = 5'b00101,
        ALU_MULHU  = 5'b00110,
        ALU_MULHSU = 5'b00111,
        ALU_DIV    = 5'b01000,
        ALU_DIVU   = 5'b01001,
        ALU_REM    = 5'b01010,
        ALU_REMU   = 5'b01011,
        ALU_SLL    = 5'b01101,
        ALU_SRA    = 5'b01110,
        ALU_SLT    = 5'b01111,
        ALU_SUB    = 5'b10000,
        ALU_SLTU   = 5'b10001,
        ALU_SRL    = 5'b10010
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef struct packed {
        alu_op_e    alu_op;
        imm_sel_e   imm_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        wb_sel_e    wb_sel;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       jump;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I(+M) decoder: instruction word -> control bundle and divide flag.
// M-extension encodings decode only when M_EXT_EN is defined; otherwise they are illegal.
module rv32_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        is_div_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register and immediate fields are consumed in the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        ctrl_o        = CTRL_BUBBLE;
        ctrl_o.funct3 = funct3;
        is_div_o      = 1'b0;
        legal         = 1'b1;
        case (opcode)
            OPC_OP: begin
                ctrl_o.reg_we = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  ctrl_o.alu_op = ALU_ADD;
                            3'b001:  ctrl_o.alu_op = ALU_SLL;
                            3'b010:  ctrl_o.alu_op = ALU_SLT;
                            3'b011:  ctrl_o.alu_op = ALU_SLTU;
                            3'b100:  ctrl_o.alu_op = ALU_XOR;
                            3'b101:  ctrl_o.alu_op = ALU_SRL;
                            3'b110:  ctrl_o.alu_op = ALU_OR;
                            default: ctrl_o.alu_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000)      ctrl_o.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) ctrl_o.alu_op = ALU_SRA;
                        else                       legal = 1'b0;
                    end
`ifdef M_EXT_EN
                    F7_MULD: begin
                        is_div_o = funct3[2];
                        case (funct3)
                            3'b000:  ctrl_o.alu_op = ALU_MUL;
                            3'b001:  ctrl_o.alu_op = ALU_MULH;
                            3'b010:  ctrl_o.alu_op = ALU_MULHSU;
                            3'b011:  ctrl_o.alu_op = ALU_MULHU;
                            3'b100:  ctrl_o.alu_op = ALU_DIV;
                            3'b101:  ctrl_o.alu_op = ALU_DIVU;
                            3'b110:  ctrl_o.alu_op = ALU_REM;
                            default: ctrl_o.alu_op = ALU_REMU;
                        endcase
                    end
`endif
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                ctrl_o.reg_we    = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                case (funct3)
                    3'b000: ctrl_o.alu_op = ALU_ADD;
                    3'b010: ctrl_o.alu_op = ALU_SLT;
                    3'b011: ctrl_o.alu_op = ALU_SLTU;
                    3'b100: ctrl_o.alu_op = ALU_XOR;
                    3'b110: ctrl_o.alu_op = ALU_OR;
                    3'b111: ctrl_o.alu_op = ALU_AND;
                    3'b001: begin
                        ctrl_o.alu_op = ALU_SLL;
                        legal         = (funct7 == F7_BASE);
                    end
                    default: begin
                        ctrl_o.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal         = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_LOAD: begin
                ctrl_o.reg_we    = 1'b1;
                ctrl_o.mem_rd    = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.wb_sel    = WB_MEM;
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                ctrl_o.mem_wr    = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.imm_sel   = IMM_S;
                legal = (funct3 <= 3'b010);
            end
            OPC_BRANCH: begin
                ctrl_o.branch  = 1'b1;
                ctrl_o.imm_sel = IMM_B;
                if (!funct3[2])     ctrl_o.alu_op = ALU_SUB;
                else if (funct3[1]) ctrl_o.alu_op = ALU_SLTU;
                else                ctrl_o.alu_op = ALU_SLT;
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_we    = 1'b1;
                ctrl_o.wb_sel    = WB_PC4;
                ctrl_o.imm_sel   = IMM_J;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_we    = 1'b1;
                ctrl_o.wb_sel    = WB_PC4;
                ctrl_o.alu_src_b = 1'b1;
                legal = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                ctrl_o.reg_we    = 1'b1;
                ctrl_o.imm_sel   = IMM_U;
                ctrl_o.alu_src_b = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_o.reg_we    = 1'b1;
                ctrl_o.imm_sel   = IMM_U;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl_o         = CTRL_BUBBLE;
            ctrl_o.funct3  = funct3;
            ctrl_o.illegal = 1'b1;
            is_div_o       = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID/EX control stage: registers the decoded bundle with stall/flush and holds
// divides for DIV_CYCLES cycles. Optional feature macro: M_EXT_EN.
module id_ex_control_stage
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W   = 5,
    parameter int unsigned IMM_SEL_W  = 3,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          instr_i,
    input  logic                 instr_valid_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic                 ready_o,
    output logic                 ex_valid_o,
    output logic [ALU_OP_W-1:0]  alu_op_o,
    output logic [IMM_SEL_W-1:0] imm_sel_o,
    output logic                 alu_src_a_o,
    output logic                 alu_src_b_o,
    output logic [1:0]           wb_sel_o,
    output logic                 reg_we_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic [2:0]           funct3_o,
    output logic                 illegal_o,
    output logic                 div_busy_o
);

    localparam int unsigned      CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    ctrl_t            dec_ctrl;
    logic             dec_is_div;
    ctrl_t            ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] div_cnt_d, div_cnt_q;
    logic             div_busy;

    rv32_decoder u_decoder (
        .instr_i  (instr_i),
        .ctrl_o   (dec_ctrl),
        .is_div_o (dec_is_div)
    );

    // Without M_EXT_EN the decoder never flags a divide, so the counter stays zero.
    assign div_busy = (div_cnt_q != '0);

    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        div_cnt_d = div_cnt_q;
        if (flush_i) begin
            ctrl_d    = CTRL_BUBBLE;
            valid_d   = 1'b0;
            div_cnt_d = '0;
        end else if (stall_i || div_busy) begin
            if (div_busy) div_cnt_d = div_cnt_q - CNT_W'(1);
        end else if (instr_valid_i) begin
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
            if (dec_is_div) div_cnt_d = DIV_LOAD;
        end else begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign ready_o     = !stall_i && !div_busy && !RESET;
    assign ex_valid_o  = valid_q;
    assign alu_op_o    = ALU_OP_W'(ctrl_q.alu_op);
    assign imm_sel_o   = IMM_SEL_W'(ctrl_q.imm_sel);
    assign alu_src_a_o = ctrl_q.alu_src_a;
    assign alu_src_b_o = ctrl_q.alu_src_b;
    assign wb_sel_o    = ctrl_q.wb_sel;
    assign reg_we_o    = ctrl_q.reg_we;
    assign mem_rd_o    = ctrl_q.mem_rd;
    assign mem_wr_o    = ctrl_q.mem_wr;
    assign branch_o    = ctrl_q.branch;
    assign jump_o      = ctrl_q.jump;
    assign funct3_o    = ctrl_q.funct3;
    assign illegal_o   = ctrl_q.illegal;
    assign div_busy_o  = div_busy;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Self-checking bench for id_ex_control_stage: directed cases plus randomized
// traffic checked against a table-driven reference of the RV32IM control rules.
module tb_id_ex_control_stage;

    localparam int unsigned DIVC = 4;
`ifdef M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    // R-type base ops and M ops indexed by funct3, using the numeric ALU codes.
    localparam logic [4:0] R_OPS [8] = '{5'd0, 5'd13, 5'd15, 5'd17, 5'd1, 5'd18, 5'd3, 5'd2};
    localparam logic [4:0] M_OPS [8] = '{5'd4, 5'd5, 5'd7, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11};
    localparam logic [6:0] OPCS  [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_o, ex_valid_o, alu_src_a_o, alu_src_b_o;
    logic [4:0]  alu_op_o;
    logic [2:0]  imm_sel_o, funct3_o;
    logic [1:0]  wb_sel_o;
    logic        reg_we_o, mem_rd_o, mem_wr_o, branch_o, jump_o, illegal_o, div_busy_o;

    id_ex_control_stage #(.ALU_OP_W(5), .IMM_SEL_W(3), .DIV_CYCLES(DIVC)) dut (
        .CLK(CLK), .RESET(RESET), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .ready_o(ready_o), .ex_valid_o(ex_valid_o),
        .alu_op_o(alu_op_o), .imm_sel_o(imm_sel_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .wb_sel_o(wb_sel_o), .reg_we_o(reg_we_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .branch_o(branch_o), .jump_o(jump_o),
        .funct3_o(funct3_o), .illegal_o(illegal_o), .div_busy_o(div_busy_o)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic        m_valid = 1'b0;
    logic [20:0] m_bundle = '0;
    int unsigned m_cnt = 0;

    logic [21:0] obs;
    assign obs = {ex_valid_o, alu_op_o, imm_sel_o, alu_src_a_o, alu_src_b_o, wb_sel_o,
                  reg_we_o, mem_rd_o, mem_wr_o, branch_o, jump_o, funct3_o, illegal_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Bundle layout: {alu_op, imm_sel, src_a, src_b, wb_sel, we, rd, wr, br, jp, funct3, illegal}
    function automatic logic [20:0] ref_dec(input logic [31:0] w, output logic is_div);
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        logic [4:0] op = 5'd0;
        logic [2:0] imm = 3'd0;
        logic [1:0] wb = 2'd0;
        logic a = 1'b0, b = 1'b0, we = 1'b0, rd = 1'b0, wr = 1'b0, br = 1'b0, jp = 1'b0;
        logic ok = 1'b0;
        is_div = 1'b0;
        case (opc)
            7'h33: begin
                we = 1'b1;
                if (f7 == 7'h00) begin ok = 1'b1; op = R_OPS[f3]; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; op = 5'd16; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; op = 5'd14; end
                else if (f7 == 7'h01 && M_EN) begin ok = 1'b1; op = M_OPS[f3]; is_div = (f3 >= 3'd4); end
            end
            7'h13: begin
                we = 1'b1; b = 1'b1;
                if (f3 == 3'd1) begin ok = (f7 == 7'h00); op = 5'd13; end
                else if (f3 == 3'd5) begin ok = (f7 == 7'h00) || (f7 == 7'h20); op = (f7 == 7'h20) ? 5'd14 : 5'd18; end
                else begin ok = 1'b1; op = R_OPS[f3]; end
            end
            7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); b = 1; rd = 1; we = 1; wb = 2'd1; end
            7'h23: begin ok = (f3 <= 3'd2); b = 1; wr = 1; imm = 3'd1; end
            7'h63: begin ok = (f3 != 2 && f3 != 3); br = 1; imm = 3'd2; op = f3[2] ? (f3[1] ? 5'd17 : 5'd15) : 5'd16; end
            7'h6F: begin ok = 1; jp = 1; we = 1; wb = 2'd2; imm = 3'd4; a = 1; b = 1; end
            7'h67: begin ok = (f3 == 0); jp = 1; we = 1; wb = 2'd2; b = 1; end
            7'h37: begin ok = 1; we = 1; b = 1; imm = 3'd3; end
            7'h17: begin ok = 1; we = 1; a = 1; b = 1; imm = 3'd3; end
            default: ok = 1'b0;
        endcase
        if (!ok) is_div = 1'b0;
        return ok ? {op, imm, a, b, wb, we, rd, wr, br, jp, f3, 1'b0} : {17'd0, f3, 1'b1};
    endfunction

    task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                        input logic st, input logic fl);
        logic d;
        RESET = rst; instr_valid_i = v; instr_i = ins; stall_i = st; flush_i = fl;
        #1;
        check("ready", 32'(ready_o), 32'(!rst && !st && m_cnt == 0));
        @(posedge CLK);
        if (rst || fl) begin
            m_valid = 1'b0; m_bundle = '0; m_cnt = 0;
        end else if (st || m_cnt > 0) begin
            if (m_cnt > 0) m_cnt--;
        end else if (v) begin
            m_bundle = ref_dec(ins, d);
            m_valid  = 1'b1;
            if (d) m_cnt = DIVC - 1;
        end else begin
            m_valid = 1'b0; m_bundle = '0;
        end
        #1;
        check("outputs", 32'(obs), 32'({m_valid, m_bundle}));
        check("div_busy", 32'(div_busy_o), 32'(m_cnt != 0));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
        int unsigned k = $urandom_range(0, 10);
        int unsigned f = $urandom_range(0, 3);
        if (k < 9) w[6:0] = OPCS[k];
        if (f == 0) w[31:25] = 7'h00;
        else if (f == 1) w[31:25] = 7'h20;
        else if (f == 2) w[31:25] = 7'h01;
        return w;
    endfunction

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0080A283;
    localparam logic [31:0] I_SW  = 32'h0050A423;
    localparam logic [31:0] I_DIV = 32'h0220C1B3;
    localparam logic [31:0] I_MUL = 32'h022081B3;
    localparam logic [31:0] I_JAL = 32'h010000EF;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    initial begin
        step(1, 1, I_ADD, 0, 0);
        step(1, 1, I_ADD, 0, 0);
        check("rst_valid", 32'(ex_valid_o), 32'd0);
        check("rst_reg_we", 32'(reg_we_o), 32'd0);

        step(0, 1, I_ADD, 0, 0);
        check("add_alu_op", 32'(alu_op_o), 32'd0);
        check("add_src_b", 32'(alu_src_b_o), 32'd0);
        check("add_reg_we", 32'(reg_we_o), 32'd1);
        check("add_wb_sel", 32'(wb_sel_o), 32'd0);
        check("add_valid", 32'(ex_valid_o), 32'd1);

        step(0, 1, I_LW, 0, 0);
        check("lw_mem_rd", 32'(mem_rd_o), 32'd1);
        check("lw_wb_sel", 32'(wb_sel_o), 32'd1);
        check("lw_imm_sel", 32'(imm_sel_o), 32'd0);
        step(0, 1, I_SW, 0, 0);
        check("sw_mem_wr", 32'(mem_wr_o), 32'd1);
        check("sw_reg_we", 32'(reg_we_o), 32'd0);
        check("sw_imm_sel", 32'(imm_sel_o), 32'd1);

        step(0, 1, I_DIV, 0, 0);
        if (M_EN) begin
            check("div_op", 32'(alu_op_o), 32'd8);
            for (int unsigned i = 0; i < DIVC - 1; i++) begin
                step(0, 1, I_ADD, 0, 0);
                check("div_hold_op", 32'(alu_op_o), 32'd8);
                check("div_hold_busy", 32'(div_busy_o), 32'(i < DIVC - 2));
            end
        end else begin
            check("div_illegal", 32'(illegal_o), 32'd1);
            check("div_valid", 32'(ex_valid_o), 32'd1);
        end
        step(0, 1, I_ADD, 0, 0);
        check("after_div_add", 32'(alu_op_o), 32'd0);

        step(0, 1, I_JAL, 0, 0);
        check("jal_jump", 32'(jump_o), 32'd1);
        step(0, 1, I_ADD, 1, 0);
        check("jal_held", 32'(jump_o), 32'd1);
        step(0, 1, I_ADD, 1, 1);
        check("flush_valid", 32'(ex_valid_o), 32'd0);
        check("flush_jump", 32'(jump_o), 32'd0);
        step(0, 1, I_DIV, 0, 0);
        step(0, 1, I_ADD, 1, 1);
        check("flush_div_busy", 32'(div_busy_o), 32'd0);

        step(0, 1, I_BAD, 0, 0);
        check("bad_illegal", 32'(illegal_o), 32'd1);
        check("bad_reg_we", 32'(reg_we_o), 32'd0);
        check("bad_mem_wr", 32'(mem_wr_o), 32'd0);
        check("bad_valid", 32'(ex_valid_o), 32'd1);
        step(0, 1, I_MUL, 0, 0);
        check("mul_illegal", 32'(illegal_o), 32'(!M_EN));
        check("mul_valid", 32'(ex_valid_o), 32'd1);

        step(0, 1, I_DIV, 0, 0);
        step(0, 1, I_ADD, 0, 0);
        step(1, 1, I_ADD, 0, 0);
        check("rst_mid_div_busy", 32'(div_busy_o), 32'd0);

        for (int unsigned i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, rand_instr(),
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
